// File: rtl/ita_hwpe_output_packer_pkg.sv
// Shared types for the ITA HWPE output packer: controller-facing structs and FSM encoding.
package ita_hwpe_output_packer_pkg;

  localparam int unsigned PACK_LEN_W = 16;

  typedef struct packed {
    logic                  start;
    logic [PACK_LEN_W-1:0] len;
  } ctrl_packer_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_packer_t;

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StDrain,
    StDone
  } packer_state_e;

endpackage

// File: rtl/ita_hwpe_output_packer_fifo.sv
// Packed-word + strobe FIFO; registered storage, output visible the cycle after a push.
module ita_hwpe_output_packer_fifo #(
  parameter int unsigned DataW = 512,
  parameter int unsigned StrbW = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [DataW-1:0]           data_i,
  input  logic [StrbW-1:0]           strb_i,
  input  logic                       pop_i,
  output logic [DataW-1:0]           data_o,
  output logic [StrbW-1:0]           strb_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     usage_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned UsageW = AddrW + 1;

  logic [DataW-1:0]  data_mem [Depth];
  logic [StrbW-1:0]  strb_mem [Depth];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [UsageW-1:0] usage_q;
  logic              push_ok, pop_ok;

  assign full_o  = (usage_q == UsageW'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AddrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   usage_q <= usage_q + UsageW'(1);
        2'b01:   usage_q <= usage_q - UsageW'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      data_mem[wptr_q] <= data_i;
      strb_mem[wptr_q] <= strb_i;
    end
  end

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign data_o = empty_o ? '0 : data_mem[rptr_q];
  assign strb_o = empty_o ? '0 : strb_mem[rptr_q];

endmodule

// File: rtl/ita_hwpe_output_packer.sv
// Packs RATIO engine beats into one wide strobed word per push, flushing a partial word at tile end.
module ita_hwpe_output_packer
  import ita_hwpe_output_packer_pkg::*;
#(
  parameter int unsigned IN_BYTES   = 16,
  parameter int unsigned OUT_BYTES  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   eng_valid_i,
  output logic                   eng_ready_o,
  input  logic [IN_BYTES*8-1:0]  eng_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OUT_BYTES*8-1:0] out_data_o,
  output logic [OUT_BYTES-1:0]   out_strb_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned Ratio  = OUT_BYTES / IN_BYTES;
  localparam int unsigned InW    = IN_BYTES * 8;
  localparam int unsigned OutW   = OUT_BYTES * 8;
  localparam int unsigned PtrW   = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int unsigned UsageW = $clog2(FIFO_DEPTH) + 1;

  packer_state_e       state_q;
  flags_packer_t       flags_q;
  logic [PtrW-1:0]     ptr_q;
  logic [LEN_W-1:0]    cnt_q, len_q;
  logic [OutW-1:0]     asm_q;

  logic                fifo_full, fifo_empty;
  logic [UsageW-1:0]   fifo_usage;
  logic                xfer, last_beat, push, pop;
  logic [OutW-1:0]     push_data;
  logic [OUT_BYTES-1:0] push_strb;

  assign eng_ready_o = (state_q == StPack) & enable_i & ~fifo_full;
  assign xfer        = eng_valid_i & eng_ready_o;
  assign last_beat   = (cnt_q == len_q - LEN_W'(1));
  assign push        = xfer & ((ptr_q == PtrW'(Ratio - 1)) | last_beat);
  assign out_valid_o = ~fifo_empty;
  assign pop         = out_valid_o & out_ready_i;
  assign busy_o      = flags_q.busy;
  assign done_o      = flags_q.done;

  // Lanes above ptr are still zero in asm_q, so unused bytes of a partial word come out as 0.
  always_comb begin
    push_data = asm_q;
    push_strb = '0;
    for (int unsigned l = 0; l < Ratio; l++) begin
      if (PtrW'(l) == ptr_q) push_data[l*InW +: InW] = eng_data_i;
      if (PtrW'(l) <= ptr_q) push_strb[l*IN_BYTES +: IN_BYTES] = '1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      flags_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      asm_q   <= '0;
    end else if (clear_i) begin
      state_q <= StIdle;
      flags_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      asm_q   <= '0;
    end else begin
      flags_q.done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q        <= len_i;
            cnt_q        <= '0;
            ptr_q        <= '0;
            asm_q        <= '0;
            flags_q.busy <= 1'b1;
            if (len_i != '0) begin
              state_q <= StPack;
            end else begin
              state_q      <= StDone;
              flags_q.done <= 1'b1;
            end
          end
        end
        StPack: begin
          if (xfer) begin
            if (push) begin
              ptr_q <= '0;
              asm_q <= '0;
            end else begin
              ptr_q <= ptr_q + PtrW'(1);
              asm_q <= push_data;
            end
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= StDrain;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        StDrain: begin
          if (fifo_empty || (pop && fifo_usage == UsageW'(1))) begin
            state_q      <= StDone;
            flags_q.done <= 1'b1;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          flags_q.busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ita_hwpe_output_packer_fifo #(
    .DataW (OutW),
    .StrbW (OUT_BYTES),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (push_data),
    .strb_i  (push_strb),
    .pop_i   (pop),
    .data_o  (out_data_o),
    .strb_o  (out_strb_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

endmodule

// File: tb/tb_ita_hwpe_output_packer.sv
// Bench for the output packer: directed tiles plus randomized tiles against a word-level model.
module tb_ita_hwpe_output_packer;

  localparam int RATIO = 4;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  s;
  } word_t;

  logic         clk_i = 1'b0;
  logic         rst_i, clear_i, enable_i, start_i;
  logic [15:0]  len_i;
  logic         eng_valid_i, eng_ready_o;
  logic [127:0] eng_data_i;
  logic         out_valid_o, out_ready_i;
  logic [511:0] out_data_o;
  logic [63:0]  out_strb_o;
  logic         busy_o, done_o;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    rmode    = 0;
  int    last_hs_cyc = 0;
  word_t exp_q[$];

  ita_hwpe_output_packer #(
    .IN_BYTES   (16),
    .OUT_BYTES  (64),
    .FIFO_DEPTH (4),
    .LEN_W      (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .enable_i    (enable_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .eng_valid_i (eng_valid_i),
    .eng_ready_o (eng_ready_o),
    .eng_data_i  (eng_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial forever #5 clk_i = ~clk_i;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, out_valid_o, 0);
    check_eq({tag, "_eready"}, eng_ready_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
    check_eq({tag, "_data"}, out_data_o, 0);
    check_eq({tag, "_strb"}, out_strb_o, 0);
  endtask

  // Sink: ready pattern chosen by rmode (0 always, 1 random, 2 held low).
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (rmode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: every handshake against the model queue, and stability while stalled.
  initial begin
    logic [511:0] pd;
    logic [63:0]  ps;
    bit           stalled;
    word_t        w;
    stalled = 0;
    pd = '0;
    ps = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i || clear_i) begin
        stalled = 0;
      end else begin
        if (out_valid_o && stalled) begin
          check_eq("stall_data", out_data_o, pd);
          check_eq("stall_strb", out_strb_o, ps);
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_word", 1, 0);
          end else begin
            w = exp_q.pop_front();
            check_eq("word_data", out_data_o, w.d);
            check_eq("word_strb", out_strb_o, w.s);
          end
          last_hs_cyc = cyc;
        end
        stalled = out_valid_o && !out_ready_i;
        pd = out_data_o;
        ps = out_strb_o;
      end
    end
  end

  task automatic run_tile(input int len, input bit kpat, input bit rnd, input bit mid_start,
                          input bit en_stall, input int abort_at, input bit abort_clr,
                          input int rm);
    logic [127:0] beats[$];
    word_t        w;
    int           k, stall_left, start_cyc, guard, to;
    bit           ms_done;
    for (int i = 0; i < len; i++) begin
      if (kpat) beats.push_back({16{8'(i)}});
      else      beats.push_back({$urandom, $urandom, $urandom, $urandom});
    end
    // Model: word j holds beats j*RATIO.. in ascending lanes, strobe covers present lanes only.
    for (int b = 0; b < len; b += RATIO) begin
      w.d = '0;
      w.s = '0;
      for (int l = 0; l < RATIO && b + l < len; l++) begin
        w.d[l*128 +: 128] = beats[b+l];
        w.s[l*16 +: 16]   = '1;
      end
      exp_q.push_back(w);
    end
    rmode = rm;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    len_i   = len[15:0];
    @(negedge clk_i);
    start_cyc  = cyc;
    k          = 0;
    stall_left = en_stall ? 5 : 0;
    ms_done    = 0;
    guard      = 0;
    while (k < len && guard < 5000) begin
      guard++;
      if (rm == 2 && k == 16 && rmode == 2) begin
        repeat (8) begin
          @(negedge clk_i);
          check_eq("bp_ready_low", eng_ready_o, 0);
        end
        check_eq("bp_valid", out_valid_o, 1);
        rmode = 0;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (mid_start && k == 2 && !ms_done) begin
        start_i = 1'b1;
        len_i   = 16'd3;
        ms_done = 1;
      end
      if (abort_at > 0 && k == abort_at) begin
        eng_valid_i = 1'b0;
        if (abort_clr) begin
          clear_i = 1'b1;
          @(posedge clk_i);
          #1;
          clear_i = 1'b0;
          check_all_zero("clear");
        end else begin
          rst_i = 1'b1;
          #1;
          check_all_zero("abort");
          @(posedge clk_i);
          #1;
          rst_i = 1'b0;
        end
        exp_q.delete();
        start_i  = 1'b0;
        enable_i = 1'b1;
        repeat (3) begin
          @(negedge clk_i);
          check_eq("abort_no_done", done_o, 0);
        end
        return;
      end
      if (en_stall && k == 2 && stall_left > 0) begin
        enable_i = 1'b0;
        stall_left--;
      end else begin
        enable_i = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
      eng_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      eng_data_i  = beats[k];
      @(negedge clk_i);
      if (!enable_i) check_eq("en_low_ready", eng_ready_o, 0);
      if (eng_valid_i && eng_ready_o) k++;
    end
    if (k < len) check_eq("beat_timeout", k, len);
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    eng_valid_i = 1'b0;
    enable_i    = 1'b1;
    to = 0;
    do begin
      @(negedge clk_i);
      to++;
    end while (!done_o && to < 2000);
    if (!done_o) begin
      check_eq("done_timeout", 0, 1);
    end else begin
      check_eq("busy_in_done", busy_o, 1);
      if (len == 0) begin
        check_eq("len0_done_lat", cyc, start_cyc + 1);
        check_eq("len0_no_valid", out_valid_o, 0);
      end else begin
        check_eq("done_after_hs", cyc, last_hs_cyc + 1);
      end
      check_eq("words_left", exp_q.size(), 0);
      @(negedge clk_i);
      check_eq("done_pulse", done_o, 0);
      check_eq("idle_busy", busy_o, 0);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    clear_i     = 1'b0;
    enable_i    = 1'b1;
    start_i     = 1'b0;
    len_i       = '0;
    eng_valid_i = 1'b0;
    eng_data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;
    //        len kpat rnd mst stl abort clr rm
    run_tile(8,  1, 0, 0, 0, 0, 0, 0);
    run_tile(6,  1, 0, 0, 0, 0, 0, 0);
    run_tile(24, 1, 0, 0, 0, 0, 0, 2);
    run_tile(0,  1, 0, 0, 0, 0, 0, 0);
    run_tile(8,  1, 0, 0, 0, 3, 0, 0);
    run_tile(4,  0, 0, 0, 0, 0, 0, 0);
    run_tile(8,  1, 0, 1, 0, 0, 0, 0);
    run_tile(8,  1, 0, 0, 1, 0, 0, 0);
    run_tile(9,  0, 1, 0, 0, 5, 1, 1);
    run_tile(5,  0, 1, 0, 0, 0, 0, 1);
    for (int t = 0; t < 8; t++) begin
      run_tile(int'($urandom_range(1, 30)), 0, 1, 0, 0, 0, 0, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
